// File: rtl/ctrl_defs.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM state codes,
// datapath select codes and the instruction classes produced by the decoder.
package ctrl_defs;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [3:0] S_IF      = 4'b0000;
  localparam logic [3:0] S_ID      = 4'b0001;
  localparam logic [3:0] S_EXE_ALU = 4'b0010;
  localparam logic [3:0] S_EXE_BR  = 4'b0011;
  localparam logic [3:0] S_EXE_MEM = 4'b0100;
  localparam logic [3:0] S_MEM_RD  = 4'b0101;
  localparam logic [3:0] S_MEM_WR  = 4'b0110;
  localparam logic [3:0] S_WB_ALU  = 4'b0111;
  localparam logic [3:0] S_WB_LD   = 4'b1000;
  localparam logic [3:0] S_HALT    = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_R31 = 2'b00;
  localparam logic [1:0] REGDST_RT  = 2'b01;
  localparam logic [1:0] REGDST_RD  = 2'b10;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_IMM  = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_JMP  = 3'd5,
    CLS_HALT = 3'd6,
    CLS_ILL  = 3'd7
  } ins_class_e;

  function automatic logic is_mem_state(input logic [3:0] st);
    return (st == S_EXE_MEM) || (st == S_MEM_RD) || (st == S_MEM_WR) || (st == S_WB_LD);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags in, selects and enables out.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       InsMemRW;
  logic       ExtSel;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] RegDst;
  logic       RegWre;
  logic       WrRegDSrc;
  logic       DBDataSrc;
  logic       mRD;
  logic       mWR;
  logic [3:0] state;
  logic       halted;

  modport master (
    input  op, zero, sign,
    output PCWre, PCSrc, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
           RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, state, halted
  );

  modport slave (
    output op, zero, sign,
    input  PCWre, PCSrc, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
           RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, state, halted
  );
endinterface

// File: rtl/mc_decode.sv
// Opcode decoder: instruction class plus the ALU/extender/operand/destination
// selects for that opcode. Purely combinational.
module mc_decode
  import ctrl_defs::*;
(
  input  logic [5:0]  i_op,
  output ins_class_e  o_class,
  output logic [2:0]  o_alu_op,
  output logic        o_ext_sel,
  output logic        o_alu_src_a,
  output logic        o_alu_src_b,
  output logic [1:0]  o_reg_dst
);

  always_comb begin
    o_class     = CLS_ILL;
    o_alu_op    = ALU_ADD;
    o_ext_sel   = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 1'b0;
    o_reg_dst   = REGDST_R31;
    case (i_op)
      OP_ADD: begin
        o_class   = CLS_R;
        o_reg_dst = REGDST_RD;
      end
      OP_SUB: begin
        o_class   = CLS_R;
        o_alu_op  = ALU_SUB;
        o_reg_dst = REGDST_RD;
      end
      OP_AND: begin
        o_class   = CLS_R;
        o_alu_op  = ALU_AND;
        o_reg_dst = REGDST_RD;
      end
      OP_OR: begin
        o_class   = CLS_R;
        o_alu_op  = ALU_OR;
        o_reg_dst = REGDST_RD;
      end
      OP_SLL: begin
        o_class     = CLS_R;
        o_alu_op    = ALU_SLL;
        o_alu_src_a = 1'b1;
        o_reg_dst   = REGDST_RD;
      end
      OP_ADDIU: begin
        o_class     = CLS_IMM;
        o_ext_sel   = 1'b1;
        o_alu_src_b = 1'b1;
        o_reg_dst   = REGDST_RT;
      end
      OP_ANDI: begin
        o_class     = CLS_IMM;
        o_alu_op    = ALU_AND;
        o_alu_src_b = 1'b1;
        o_reg_dst   = REGDST_RT;
      end
      OP_ORI: begin
        o_class     = CLS_IMM;
        o_alu_op    = ALU_OR;
        o_alu_src_b = 1'b1;
        o_reg_dst   = REGDST_RT;
      end
      OP_SLTI: begin
        o_class     = CLS_IMM;
        o_alu_op    = ALU_SLT;
        o_ext_sel   = 1'b1;
        o_alu_src_b = 1'b1;
        o_reg_dst   = REGDST_RT;
      end
      OP_LW: begin
        o_class     = CLS_LD;
        o_ext_sel   = 1'b1;
        o_alu_src_b = 1'b1;
        o_reg_dst   = REGDST_RT;
      end
      OP_SW: begin
        o_class     = CLS_ST;
        o_ext_sel   = 1'b1;
        o_alu_src_b = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLTZ: begin
        o_class   = CLS_BR;
        o_alu_op  = ALU_SUB;
        o_ext_sel = 1'b1;
      end
      OP_J, OP_JR, OP_JAL: o_class = CLS_JMP;
      OP_HALT:             o_class = CLS_HALT;
      default:             o_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EXE/MEM/WB over the shared datapath
// and drives every datapath select and enable.
module multicycle_ctrl
  import ctrl_defs::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input logic               CLK,
  input logic               Reset_n,
  multicycle_ctrl_if.master bus
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op_q;
  logic [5:0] w_op;

  ins_class_e w_class;
  logic [2:0] w_alu_op;
  logic       w_ext_sel;
  logic       w_src_a;
  logic       w_src_b;
  logic [1:0] w_reg_dst;
  logic       w_taken;
  logic       w_post;

  logic       w_pc_wre;
  logic [1:0] w_pc_src;
  logic       w_ir_wre;
  logic       w_ins_rd;
  logic       w_ext_o;
  logic       w_src_a_o;
  logic       w_src_b_o;
  logic [2:0] w_alu_op_o;
  logic [1:0] w_reg_dst_o;
  logic       w_reg_wre;
  logic       w_wr_src;
  logic       w_db_src;
  logic       w_mrd;
  logic       w_mwr;

  // In ID the opcode comes straight from IR; afterwards the latched copy is used
  // so the datapath selects stay stable even if IR is reloaded.
  assign w_op = (r_state == S_ID) ? bus.op : r_op_q;

  mc_decode u_decode (
    .i_op        (w_op),
    .o_class     (w_class),
    .o_alu_op    (w_alu_op),
    .o_ext_sel   (w_ext_sel),
    .o_alu_src_a (w_src_a),
    .o_alu_src_b (w_src_b),
    .o_reg_dst   (w_reg_dst)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_BEQ:  w_taken = bus.zero;
      OP_BNE:  w_taken = ~bus.zero;
      OP_BLTZ: w_taken = bus.sign;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        case (w_class)
          CLS_JMP:        w_next = S_IF;
          CLS_HALT:       w_next = S_HALT;
          CLS_BR:         w_next = S_EXE_BR;
          CLS_LD, CLS_ST: w_next = S_EXE_MEM;
          CLS_R, CLS_IMM: w_next = S_EXE_ALU;
          default:        w_next = ILLEGAL_HALT ? S_HALT : S_IF;
        endcase
      end
      S_EXE_ALU: w_next = S_WB_ALU;
      S_WB_ALU:  w_next = S_IF;
      S_EXE_BR:  w_next = S_IF;
      S_EXE_MEM: w_next = (w_class == CLS_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_next = S_WB_LD;
      S_WB_LD:   w_next = S_IF;
      S_MEM_WR:  w_next = S_IF;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state <= S_IF;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID) begin
        r_op_q <= bus.op;
      end
    end
  end

  assign w_post = (r_state == S_EXE_ALU) || (r_state == S_EXE_BR) || (r_state == S_WB_ALU)
                  || is_mem_state(r_state);

  always_comb begin
    w_pc_src    = PCSRC_NEXT;
    w_ir_wre    = 1'b0;
    w_ins_rd    = 1'b0;
    w_ext_o     = 1'b0;
    w_src_a_o   = 1'b0;
    w_src_b_o   = 1'b0;
    w_alu_op_o  = ALU_ADD;
    w_reg_dst_o = REGDST_R31;
    w_reg_wre   = 1'b0;
    w_wr_src    = 1'b0;
    w_db_src    = 1'b0;
    w_mrd       = 1'b0;
    w_mwr       = 1'b0;
    // ALU-side selects are held from EXE through MEM/WB of the same instruction.
    if (w_post) begin
      w_ext_o    = w_ext_sel;
      w_src_a_o  = w_src_a;
      w_src_b_o  = w_src_b;
      w_alu_op_o = w_alu_op;
    end
    case (r_state)
      S_IF: begin
        w_ir_wre = 1'b1;
        w_ins_rd = 1'b1;
      end
      S_ID: begin
        if (w_class == CLS_JMP) begin
          w_pc_src = (w_op == OP_JR) ? PCSRC_RS : PCSRC_JUMP;
        end
        if (w_op == OP_JAL) begin
          w_reg_wre   = 1'b1;
          w_reg_dst_o = REGDST_R31;
          w_wr_src    = 1'b0;
        end
      end
      S_EXE_BR: begin
        if (w_taken) begin
          w_pc_src = PCSRC_BRANCH;
        end
      end
      S_MEM_RD: w_mrd = 1'b1;
      S_MEM_WR: w_mwr = 1'b1;
      S_WB_ALU: begin
        w_reg_wre   = 1'b1;
        w_wr_src    = 1'b1;
        w_reg_dst_o = w_reg_dst;
      end
      S_WB_LD: begin
        w_reg_wre   = 1'b1;
        w_db_src    = 1'b1;
        w_wr_src    = 1'b1;
        w_reg_dst_o = REGDST_RT;
      end
      default: ;
    endcase
  end

  assign w_pc_wre = (w_next == S_IF);

  // Reset overrides everything combinationally so an aborted instruction cannot write.
  assign bus.PCWre     = Reset_n & w_pc_wre;
  assign bus.PCSrc     = Reset_n ? w_pc_src : '0;
  assign bus.IRWre     = Reset_n & w_ir_wre;
  assign bus.InsMemRW  = Reset_n & w_ins_rd;
  assign bus.ExtSel    = Reset_n & w_ext_o;
  assign bus.ALUSrcA   = Reset_n & w_src_a_o;
  assign bus.ALUSrcB   = Reset_n & w_src_b_o;
  assign bus.ALUOp     = Reset_n ? w_alu_op_o : '0;
  assign bus.RegDst    = Reset_n ? w_reg_dst_o : '0;
  assign bus.RegWre    = Reset_n & w_reg_wre;
  assign bus.WrRegDSrc = Reset_n & w_wr_src;
  assign bus.DBDataSrc = Reset_n & w_db_src;
  assign bus.mRD       = Reset_n & w_mrd;
  assign bus.mWR       = Reset_n & w_mwr;
  assign bus.state     = r_state;
  assign bus.halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: two instances (unknown opcode halts /
// retires as NOP) driven identically and checked against an instruction-level model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       halted;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       InsMemRW;
    logic       ExtSel;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] RegDst;
    logic       RegWre;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
  } rec_t;

  localparam logic [3:0] T_IF = 4'h0, T_ID = 4'h1, T_EXE_ALU = 4'h2, T_EXE_BR = 4'h3;
  localparam logic [3:0] T_EXE_MEM = 4'h4, T_MEM_RD = 4'h5, T_MEM_WR = 4'h6;
  localparam logic [3:0] T_WB_ALU = 4'h7, T_WB_LD = 4'h8, T_HALT = 4'hF;
  localparam int K_R = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JMP = 5, K_HLT = 6, K_ILL = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] tb_op;
  logic       tb_zero;
  logic       tb_sign;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus_h ();
  multicycle_ctrl_if bus_n ();

  assign bus_h.op   = tb_op;
  assign bus_h.zero = tb_zero;
  assign bus_h.sign = tb_sign;
  assign bus_n.op   = tb_op;
  assign bus_n.zero = tb_zero;
  assign bus_n.sign = tb_sign;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (.CLK(clk), .Reset_n(rst_n), .bus(bus_h));
  multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut_n (.CLK(clk), .Reset_n(rst_n), .bus(bus_n));

  rec_t act_h, act_n;
  assign act_h = {bus_h.state, bus_h.halted, bus_h.PCWre, bus_h.PCSrc, bus_h.IRWre, bus_h.InsMemRW,
                  bus_h.ExtSel, bus_h.ALUSrcA, bus_h.ALUSrcB, bus_h.ALUOp, bus_h.RegDst,
                  bus_h.RegWre, bus_h.WrRegDSrc, bus_h.DBDataSrc, bus_h.mRD, bus_h.mWR};
  assign act_n = {bus_n.state, bus_n.halted, bus_n.PCWre, bus_n.PCSrc, bus_n.IRWre, bus_n.InsMemRW,
                  bus_n.ExtSel, bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ALUOp, bus_n.RegDst,
                  bus_n.RegWre, bus_n.WrRegDSrc, bus_n.DBDataSrc, bus_n.mRD, bus_n.mWR};

  rec_t exp_h[$], exp_n[$];
  int   id_h[$], id_n[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;
  bit   halted_m[2];
  logic [3:0] cur_m[2];

  // ---------------- reference model ----------------
  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b011000: return K_R;
      6'b000010, 6'b010000, 6'b010010, 6'b100110:            return K_IMM;
      6'b110001:                                             return K_LD;
      6'b110000:                                             return K_ST;
      6'b110100, 6'b110101, 6'b110110:                       return K_BR;
      6'b111000, 6'b111001, 6'b111010:                       return K_JMP;
      6'b111111:                                             return K_HLT;
      default:                                               return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110100, 6'b110101, 6'b110110: return 3'b001;
      6'b011000:                                  return 3'b010;
      6'b010010, 6'b010011:                       return 3'b011;
      6'b010000, 6'b010001:                       return 3'b100;
      6'b100110:                                  return 3'b101;
      default:                                    return 3'b000;
    endcase
  endfunction

  function automatic logic ext_of(input logic [5:0] op);
    return op inside {6'b000010, 6'b100110, 6'b110001, 6'b110000, 6'b110100, 6'b110101, 6'b110110};
  endfunction

  function automatic int path_len(input logic [5:0] op);
    case (kind_of(op))
      K_R, K_IMM, K_ST: return 4;
      K_LD:             return 5;
      K_BR:             return 3;
      default:          return 2;
    endcase
  endfunction

  function automatic logic [3:0] path_at(input logic [5:0] op, input int k);
    int kd;
    kd = kind_of(op);
    if (k == 0) return T_IF;
    if (k == 1) return T_ID;
    if (k == 2) return (kd == K_BR) ? T_EXE_BR : ((kd == K_LD || kd == K_ST) ? T_EXE_MEM : T_EXE_ALU);
    if (k == 3) return (kd == K_LD) ? T_MEM_RD : ((kd == K_ST) ? T_MEM_WR : T_WB_ALU);
    return T_WB_LD;
  endfunction

  function automatic rec_t halt_rec();
    rec_t r;
    r = '0;
    r.state  = T_HALT;
    r.halted = 1'b1;
    return r;
  endfunction

  function automatic rec_t step_rec(input int d, input logic [5:0] op, input int k,
                                    input logic z, input logic s);
    rec_t r;
    int   kd;
    bit   halting;
    bit   taken;
    r  = '0;
    kd = kind_of(op);
    halting = (kd == K_HLT) || (kd == K_ILL && d == 0);
    taken   = (op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s);
    r.state = path_at(op, k);
    if (k >= 2) begin
      r.ExtSel  = ext_of(op);
      r.ALUSrcA = (op == 6'b011000);
      r.ALUSrcB = (kd == K_IMM || kd == K_LD || kd == K_ST);
      r.ALUOp   = alu_of(op);
    end
    r.PCWre = (k == path_len(op) - 1) && !halting;
    if (k == 0) begin
      r.IRWre    = 1'b1;
      r.InsMemRW = 1'b1;
    end
    if (k == 1) begin
      if (op == 6'b111000 || op == 6'b111010) r.PCSrc = 2'b11;
      if (op == 6'b111001) r.PCSrc = 2'b10;
      if (op == 6'b111010) r.RegWre = 1'b1;
    end
    case (r.state)
      T_EXE_BR: if (taken) r.PCSrc = 2'b01;
      T_MEM_RD: r.mRD = 1'b1;
      T_MEM_WR: r.mWR = 1'b1;
      T_WB_ALU: begin
        r.RegWre    = 1'b1;
        r.WrRegDSrc = 1'b1;
        r.RegDst    = (kd == K_IMM) ? 2'b01 : 2'b10;
      end
      T_WB_LD: begin
        r.RegWre    = 1'b1;
        r.DBDataSrc = 1'b1;
        r.WrRegDSrc = 1'b1;
        r.RegDst    = 2'b01;
      end
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cycle_push(input rec_t eh, input rec_t en);
    exp_h.push_back(eh);
    id_h.push_back(step);
    exp_n.push_back(en);
    id_n.push_back(step);
    step++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rec_t er[2];
    for (int i = 0; i < n; i++) begin
      rst_n   = 1'b0;
      tb_op   = 6'($urandom);
      tb_zero = 1'($urandom);
      tb_sign = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
        er[d] = '0;
        er[d].state  = (i == 0) ? cur_m[d] : T_IF;
        er[d].halted = (er[d].state == T_HALT);
      end
      cycle_push(er[0], er[1]);
    end
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cur_m[d]    = T_IF;
      halted_m[d] = 1'b0;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      tb_op   = 6'($urandom);
      tb_zero = 1'($urandom);
      tb_sign = 1'($urandom);
      cycle_push(halt_rec(), halt_rec());
    end
  endtask

  // zf/sf < 0 means random flag; abort_k >= 0 pulls reset in that cycle of the instruction.
  task automatic issue(input logic [5:0] op, input int zf, input int sf, input int abort_k);
    rec_t er[2];
    int   len;
    int   kd;
    len = path_len(op);
    kd  = kind_of(op);
    for (int k = 0; k < len; k++) begin
      tb_op   = (k == 1) ? op : 6'($urandom);
      tb_zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      tb_sign = (sf < 0) ? 1'($urandom) : 1'(sf);
      if (k == abort_k) begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
          er[d] = '0;
          er[d].state  = halted_m[d] ? T_HALT : path_at(op, k);
          er[d].halted = halted_m[d];
        end
        cycle_push(er[0], er[1]);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
          cur_m[d]    = T_IF;
          halted_m[d] = 1'b0;
        end
        return;
      end
      for (int d = 0; d < 2; d++) begin
        er[d] = halted_m[d] ? halt_rec() : step_rec(d, op, k, tb_zero, tb_sign);
      end
      cycle_push(er[0], er[1]);
    end
    for (int d = 0; d < 2; d++) begin
      if (kd == K_HLT || (kd == K_ILL && d == 0)) halted_m[d] = 1'b1;
      cur_m[d] = halted_m[d] ? T_HALT : T_IF;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    rec_t e;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_h.size() > 0) begin
        e  = exp_h.pop_front();
        id = id_h.pop_front();
        n_tests++;
        if (act_h !== e) begin
          n_fail++;
          $display("FAIL dut_h step=%0d state=%h act=%h exp=%h", id, act_h.state, act_h, e);
        end
      end
      if (exp_n.size() > 0) begin
        e  = exp_n.pop_front();
        id = id_n.pop_front();
        n_tests++;
        if (act_n !== e) begin
          n_fail++;
          $display("FAIL dut_n step=%0d state=%h act=%h exp=%h", id, act_n.state, act_n, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [5:0] legal [18] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                             6'b010011, 6'b011000, 6'b100110, 6'b110000, 6'b110001, 6'b110100,
                             6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010, 6'b111111};

  initial begin
    logic [5:0] op;
    int         ab;
    rst_n   = 1'b0;
    tb_op   = '0;
    tb_zero = 1'b0;
    tb_sign = 1'b0;
    cur_m[0] = T_IF;
    cur_m[1] = T_IF;
    @(posedge clk);
    #1;
    do_reset(2);

    issue(6'b000010, -1, -1, -1);  // addiu
    issue(6'b110001, -1, -1, -1);  // lw
    issue(6'b110100,  1, -1, -1);  // beq taken
    issue(6'b110100,  0, -1, -1);  // beq not taken
    issue(6'b110110, -1,  1, -1);  // bltz taken
    issue(6'b110110, -1,  0, -1);  // bltz not taken
    issue(6'b110101,  0, -1, -1);  // bne taken
    issue(6'b111010, -1, -1, -1);  // jal
    issue(6'b111000, -1, -1, -1);  // j
    issue(6'b111001, -1, -1, -1);  // jr
    issue(6'b010010, -1, -1, -1);  // ori
    issue(6'b011000, -1, -1, -1);  // sll
    issue(6'b110000, -1, -1,  2);  // sw aborted in EXE_MEM
    issue(6'b110000, -1, -1, -1);  // sw
    issue(6'b101010, -1, -1, -1);  // unknown: one instance halts, the other retires it
    issue(6'b000000, -1, -1, -1);
    issue(6'b111111, -1, -1, -1);  // halt
    hold(10);
    do_reset(2);

    for (int i = 0; i < 220; i++) begin
      if (halted_m[0] && halted_m[1]) begin
        hold($urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
      if ($urandom_range(0, 14) == 0) begin
        op = 6'b101010;
        for (int t = 0; t < 64; t++) begin
          op = 6'($urandom);
          if (kind_of(op) == K_ILL) break;
        end
        if (kind_of(op) != K_ILL) op = 6'b101010;
      end else begin
        op = legal[$urandom_range(0, 17)];
      end
      ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, path_len(op) - 1)) : -1;
      issue(op, -1, -1, ab);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_h.size() != 0 || exp_n.size() != 0) begin
      n_fail++;
      $display("FAIL drain act=%0d/%0d exp=0/0", exp_h.size(), exp_n.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
